// File: rtl/spi_sram_responder_pkg.sv
// Shared constants, FSM encoding and pad-drive helper for the serial SRAM responder.
package spi_sram_responder_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_EQIO   = 8'h38;
    localparam logic [7:0] CMD_RSTIO  = 8'hFF;
    localparam int         ADDR_BITS  = 24;
    localparam int         DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    // SPI mode drives only SIO1; SQI drives the whole top nibble
    function automatic logic [3:0] sio_drive(input logic quad, input logic [7:0] b);
        return quad ? b[7:4] : {2'b00, b[7], 1'b0};
    endfunction

endpackage

// File: rtl/spi_sram_responder_sync.sv
// Multi-stage synchroniser with rise/fall pulses on the synchronised value.
module spi_sync_edge
    import spi_sram_responder_pkg::*;
#(
    parameter int               STAGES  = 2,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]             prev_q, prev_d;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = sync_q[STAGES-1];
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/spi_sram_responder.sv
// 23LC1024-style serial SRAM target (SPI/SQI) backed by on-chip memory.
// Optional sticky protocol_error output when SPI_SRAM_RESPONDER_ERR_EN is defined.
module spi_sram_responder
    import spi_sram_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sram_cs_n,
    input  logic       sram_sck,
    input  logic [3:0] sram_sio_i,
    output logic [3:0] sram_sio_o,
    output logic       sram_sio_oe,
    output logic       quad_mode
`ifdef SPI_SRAM_RESPONDER_ERR_EN
    ,
    output logic       protocol_error
`endif
);

    localparam int AW = MEM_ADDR_WIDTH;

    logic       cs_n_s, sck_rise, sck_fall;
    logic [3:0] sio_s;
    logic       sck_s_unused, cs_rise_unused, cs_fall_unused;
    logic [3:0] sio_rise_unused, sio_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .d(sram_sck),
        .q(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .d(sram_cs_n),
        .q(cs_n_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(4), .RST_VAL(4'h0)) u_sio (
        .clk(clk), .reset(reset), .d(sram_sio_i),
        .q(sio_s), .rise(sio_rise_unused), .fall(sio_fall_unused)
    );

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          quad_q, quad_d;
    logic          oe_q, oe_d;
    logic [3:0]    sio_o_q, sio_o_d;
`ifdef SPI_SRAM_RESPONDER_ERR_EN
    logic          err_q, err_d;
`endif

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    mem_rdata;
    logic          mem_we, load;
    logic [4:0]    bpe, cnt_inc;
    logic [7:0]    sh_in, sh_out;
    logic [AW-1:0] addr_in;

    always_comb begin
        bpe     = quad_q ? 5'd4 : 5'd1;
        cnt_inc = cnt_q + bpe;
        sh_in   = quad_q ? {sh_q[3:0], sio_s} : {sh_q[6:0], sio_s[0]};
        sh_out  = quad_q ? {sh_q[3:0], 4'h0} : {sh_q[6:0], 1'b0};
        addr_in = quad_q ? {addr_q[AW-5:0], sio_s} : {addr_q[AW-2:0], sio_s[0]};

        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        quad_d  = quad_q;
        oe_d    = oe_q;
        sio_o_d = sio_o_q;
        mem_we  = 1'b0;
        load    = 1'b0;
`ifdef SPI_SRAM_RESPONDER_ERR_EN
        err_d   = err_q;
`endif

        // Deselect overrides any SCK activity seen in the same cycle
        if (cs_n_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            sio_o_d = '0;
`ifdef SPI_SRAM_RESPONDER_ERR_EN
            if (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DUMMY ||
                (state_q == ST_WDATA && cnt_q != 5'd0) ||
                (state_q == ST_RDATA && cnt_q != 5'd0 && cnt_q != 5'd8))
                err_d = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
                ST_CMD: if (sck_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_inc;
                    if (cnt_inc == 5'd8) begin
                        cnt_d   = '0;
                        state_d = ST_IGNORE;
                        case (sh_in)
                            CMD_WRITE: begin state_d = ST_ADDR; rd_d = 1'b0; end
                            CMD_READ:  begin state_d = ST_ADDR; rd_d = 1'b1; end
                            CMD_EQIO:  quad_d = 1'b1;
                            CMD_RSTIO: quad_d = 1'b0;
                            default: begin
`ifdef SPI_SRAM_RESPONDER_ERR_EN
                                err_d = 1'b1;
`endif
                            end
                        endcase
                    end
                end
                ST_ADDR: if (sck_rise) begin
                    addr_d = addr_in;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == 5'(ADDR_BITS)) begin
                        cnt_d   = '0;
                        state_d = rd_q ? ST_DUMMY : ST_WDATA;
                    end
                end
                // mem_rdata tracks mem[addr_q] continuously, so the first byte is ready here
                ST_DUMMY: begin
                    if (sck_rise && cnt_q != 5'(DUMMY_BITS)) begin
                        cnt_d = cnt_inc;
                    end else if (sck_fall && cnt_q == 5'(DUMMY_BITS)) begin
                        load    = 1'b1;
                        oe_d    = 1'b1;
                        state_d = ST_RDATA;
                    end
                end
                // cnt counts bits the initiator has sampled; 8 means the byte is consumed
                ST_RDATA: begin
                    if (sck_rise && cnt_q != 5'd8) begin
                        cnt_d = cnt_inc;
                    end else if (sck_fall) begin
                        if (cnt_q == 5'd8) begin
                            load = 1'b1;
                        end else begin
                            sh_d    = sh_out;
                            sio_o_d = sio_drive(quad_q, sh_out);
                        end
                    end
                end
                ST_WDATA: if (sck_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_inc;
                    if (cnt_inc == 5'd8) begin
                        mem_we = 1'b1;
                        cnt_d  = '0;
                        addr_d = addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // addr_q moves on to the prefetch address once a byte enters the shifter
        if (load) begin
            sh_d    = mem_rdata;
            sio_o_d = sio_drive(quad_q, mem_rdata);
            cnt_d   = '0;
            addr_d  = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            quad_q  <= 1'b0;
            oe_q    <= 1'b0;
            sio_o_q <= '0;
`ifdef SPI_SRAM_RESPONDER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            quad_q  <= quad_d;
            oe_q    <= oe_d;
            sio_o_q <= sio_o_d;
`ifdef SPI_SRAM_RESPONDER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[addr_q] <= sh_in;
        mem_rdata <= mem[addr_q];
    end

    assign sram_sio_o  = sio_o_q;
    assign sram_sio_oe = oe_q;
    assign quad_mode   = quad_q;
`ifdef SPI_SRAM_RESPONDER_ERR_EN
    assign protocol_error = err_q;
`endif

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench: drives SPI/SQI transactions as the initiator and checks read-back and mode flags.
module tb_spi_sram_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sram_cs_n = 1'b1;
    logic       sram_sck = 1'b0;
    logic [3:0] sram_sio_i = 4'h0;
    logic [3:0] sram_sio_o;
    logic       sram_sio_oe;
    logic       quad_mode;
`ifdef SPI_SRAM_RESPONDER_ERR_EN
    logic       protocol_error;
`endif

    int checks = 0;
    int failures = 0;

    spi_sram_responder #(.MEM_ADDR_WIDTH(10), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sram_cs_n(sram_cs_n), .sram_sck(sram_sck),
        .sram_sio_i(sram_sio_i), .sram_sio_o(sram_sio_o), .sram_sio_oe(sram_sio_oe),
        .quad_mode(quad_mode)
`ifdef SPI_SRAM_RESPONDER_ERR_EN
        , .protocol_error(protocol_error)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One SCK period per bit (SPI) or nibble (SQI); captures SIO1/SIO[3:0] at each rise.
    task automatic shift(input logic q, input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        int n;
        rx = '0;
        n  = q ? nbits / 4 : nbits;
        for (int i = 0; i < n; i++) begin
            if (q) sram_sio_i = tx[nbits-1-4*i -: 4];
            else   sram_sio_i = {3'b000, tx[nbits-1-i]};
            #40 sram_sck = 1'b1;
            rx = q ? {rx[27:0], sram_sio_o} : {rx[30:0], sram_sio_o[1]};
            #40 sram_sck = 1'b0;
        end
        sram_sio_i = 4'h0;
    endtask

    task automatic cs_on();
        sram_cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_off();
        #40 sram_cs_n = 1'b1;
        #200;
    endtask

    task automatic send_cmd(input logic q, input logic [7:0] cmd);
        logic [31:0] rx;
        cs_on();
        shift(q, {24'h0, cmd}, 8, rx);
        cs_off();
    endtask

    task automatic wr(input logic q, input logic [23:0] addr, input logic [31:0] data, input int nbytes);
        logic [31:0] rx;
        cs_on();
        shift(q, 32'h02, 8, rx);
        shift(q, {8'h0, addr}, 24, rx);
        shift(q, data, nbytes * 8, rx);
        cs_off();
    endtask

    task automatic rd(input logic q, input logic [23:0] addr, input int nbytes, output logic [31:0] data);
        logic [31:0] rx;
        cs_on();
        shift(q, 32'h03, 8, rx);
        shift(q, {8'h0, addr}, 24, rx);
        shift(q, 32'h0, 8, rx);
        shift(q, 32'h0, nbytes * 8, data);
        chk("rd_oe_active", {31'h0, sram_sio_oe}, 32'h1);
        cs_off();
        chk("rd_oe_released", {31'h0, sram_sio_oe}, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] rx;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_sio_o", {28'h0, sram_sio_o}, 32'h0);
        chk("rst_oe", {31'h0, sram_sio_oe}, 32'h0);
        chk("rst_quad", {31'h0, quad_mode}, 32'h0);
        @(negedge clk) reset = 1'b0;
        #100;

        // SPI write/read, address masked to 10 bits
        wr(1'b0, 24'h001536, 32'h0000650F, 2);
        rd(1'b0, 24'h001536, 2, d);
        chk("spi_rd2", d, 32'h0000650F);
        rd(1'b0, 24'h00F136, 1, d);
        chk("spi_rd_mask", d, 32'h00000065);
        send_cmd(1'b0, 8'hFF);
        chk("rstio_in_spi", {31'h0, quad_mode}, 32'h0);

        // Enter SQI
        send_cmd(1'b0, 8'h38);
        chk("eqio_quad", {31'h0, quad_mode}, 32'h1);
        send_cmd(1'b1, 8'h38);
        chk("eqio_in_sqi", {31'h0, quad_mode}, 32'h1);
        wr(1'b1, 24'h000010, 32'h0000650F, 2);
        rd(1'b1, 24'h000010, 2, d);
        chk("sqi_rd2", d, 32'h0000650F);

        // SQI write wrapping past the top of memory
        wr(1'b1, 24'h0003FF, 32'hA1B2C3D4, 4);
        rd(1'b1, 24'h0003FF, 4, d);
        chk("sqi_wrap_rd4", d, 32'hA1B2C3D4);
        rd(1'b1, 24'h000000, 1, d);
        chk("sqi_wrap_0", d, 32'h000000B2);
        rd(1'b1, 24'h000002, 1, d);
        chk("sqi_wrap_2", d, 32'h000000D4);

        // Partial byte discarded on early deselect
        wr(1'b1, 24'h000100, 32'h00001122, 2);
`ifdef SPI_SRAM_RESPONDER_ERR_EN
        chk("err_clear", {31'h0, protocol_error}, 32'h0);
`endif
        cs_on();
        shift(1'b1, 32'h02, 8, rx);
        shift(1'b1, 32'h000100, 24, rx);
        shift(1'b1, 32'h650, 12, rx);
        cs_off();
        chk("partial_oe", {31'h0, sram_sio_oe}, 32'h0);
`ifdef SPI_SRAM_RESPONDER_ERR_EN
        chk("err_partial", {31'h0, protocol_error}, 32'h1);
`endif
        rd(1'b1, 24'h000100, 2, d);
        chk("partial_rd", d, 32'h00006522);

        // Back to SPI
        send_cmd(1'b1, 8'hFF);
        chk("rstio_quad", {31'h0, quad_mode}, 32'h0);
        rd(1'b0, 24'h001536, 2, d);
        chk("spi_after_rstio", d, 32'h0000650F);

        // Reset in the middle of an SQI read
        send_cmd(1'b0, 8'h38);
        chk("eqio_again", {31'h0, quad_mode}, 32'h1);
        cs_on();
        shift(1'b1, 32'h03, 8, rx);
        shift(1'b1, 32'h001536, 24, rx);
        shift(1'b1, 32'h0, 8, rx);
        shift(1'b1, 32'h0, 4, rx);
        chk("mid_rd_nibble", rx, 32'h6);
        chk("mid_rd_oe", {31'h0, sram_sio_oe}, 32'h1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_oe", {31'h0, sram_sio_oe}, 32'h0);
        chk("mid_rst_quad", {31'h0, quad_mode}, 32'h0);
        chk("mid_rst_sio_o", {28'h0, sram_sio_o}, 32'h0);
        @(negedge clk) reset = 1'b0;
        sram_cs_n = 1'b1;
        #200;
        rd(1'b0, 24'h0003FF, 1, d);
        chk("post_rst_rd", d, 32'h000000A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
